// File: rtl/note_decoder_pkg.sv
// Shared note table, state type and period classifier for note_decoder.
package note_decoder_pkg;

  localparam int         PER_W     = 18;
  localparam logic [3:0] NOTE_REST = 4'hF;

  // Nominal full periods at 50 MHz, C4..C5.
  localparam int NOTE_PERIOD [0:7] = '{191113, 170264, 151685, 143172,
                                       127551, 113636, 101239, 95557};

  typedef enum logic [1:0] {SILENT, ACQUIRE, TRACK} state_t;

  // Returns the matching note index or NOTE_REST; the lowest index wins where two windows touch.
  function automatic logic [3:0] classify_period(input logic [PER_W-1:0] period,
                                                 input int period_shift,
                                                 input int tol_shift);
    int         nominal;
    int         tol;
    int         diff;
    logic [3:0] note;
    note = NOTE_REST;
    for (int k = 7; k >= 0; k--) begin
      nominal = NOTE_PERIOD[k] >> period_shift;
      tol     = nominal >> tol_shift;
      diff    = int'(period) - nominal;
      if (diff < 0) diff = -diff;
      if (diff <= tol) note = 4'(k);
    end
    return note;
  endfunction

endpackage

// File: rtl/note_decoder_period_meter.sv
// Tone input synchronizer, rising-edge detector, saturating period counter and silence strobe.
module period_meter
  import note_decoder_pkg::*;
#(
  parameter int MAX_PERIOD = 250000
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_tone,
  output logic             o_edge_stb,
  output logic [PER_W-1:0] o_period,
  output logic             o_silence_stb
);

  localparam logic [PER_W-1:0] CNT_MAX = PER_W'(MAX_PERIOD);

  // [1:0] is the synchronizer, [2] the delayed copy for edge detection.
  logic [2:0]       r_sync;
  logic [PER_W-1:0] r_cnt;
  logic             w_edge;

  assign w_edge = r_sync[1] & ~r_sync[2];

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_sync <= '0;
      r_cnt  <= CNT_MAX;
    end else begin
      r_sync <= {r_sync[1:0], i_tone};
      if (w_edge) begin
        r_cnt <= PER_W'(1);
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_edge_stb    = w_edge;
  assign o_period      = r_cnt;
  assign o_silence_stb = !w_edge && (r_cnt == CNT_MAX - 1'b1);

endmodule

// File: rtl/note_decoder.sv
// Decodes a square-wave tone into (note, duration) records on a valid/ready port.
// Optional macro REST_REPORT_EN: also emit (4'hF, silence length) records for rests.
module note_decoder
  import note_decoder_pkg::*;
#(
  parameter int TICK_CYCLES  = 500000,
  parameter int MAX_PERIOD   = 250000,
  parameter int STABLE_CNT   = 4,
  parameter int TOL_SHIFT    = 5,
  parameter int DUR_W        = 12,
  parameter int PERIOD_SHIFT = 0
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_tone_in,
  input  logic             i_out_ready,
  output logic             o_out_valid,
  output logic [3:0]       o_note_out,
  output logic [DUR_W-1:0] o_dur_out,
  output logic [3:0]       o_note_live,
  output logic             o_overrun
);

  localparam int               PRE_W    = $clog2(TICK_CYCLES + 1);
  localparam int               T_W      = DUR_W + PRE_W;
  localparam int               CNT_W    = $clog2(STABLE_CNT + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);
  localparam logic [DUR_W-1:0] DUR_MAX  = '1;
  localparam logic [T_W-1:0]   TIME_ONE = T_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  // Elapsed time is kept as {duration units, prescaler}; the unit field saturates.
  function automatic logic [T_W-1:0] tick_inc(input logic [T_W-1:0] t);
    logic [DUR_W-1:0] dur;
    logic [PRE_W-1:0] pre;
    {dur, pre} = t;
    if (pre != PRE_LAST) begin
      pre = pre + 1'b1;
    end else begin
      pre = '0;
      if (dur != DUR_MAX) dur = dur + 1'b1;
    end
    return {dur, pre};
  endfunction

  logic             w_edge;
  logic             w_silence;
  logic [PER_W-1:0] w_period;
  logic [3:0]       w_note;
  logic             w_cand_hit;
  logic             w_live_hit;
  logic             w_emit;
  logic [3:0]       w_emit_note;
  logic [DUR_W-1:0] w_emit_dur;
  logic [T_W-1:0]   w_time_inc;
  logic [T_W-1:0]   w_miss_inc;
  logic [DUR_W-1:0] w_dur_now;
  logic [CNT_W-1:0] w_new_cnt;

  state_t           r_state;
  logic [T_W-1:0]   r_time;
  logic [T_W-1:0]   r_miss_time;
  logic [DUR_W-1:0] r_frozen;
  logic [3:0]       r_cand;
  logic [3:0]       r_live;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_miss;
  logic             r_valid;
  logic [3:0]       r_note_out;
  logic [DUR_W-1:0] r_dur_out;
  logic             r_overrun;
`ifdef REST_REPORT_EN
  logic             r_rest_armed;
`endif

  period_meter #(.MAX_PERIOD(MAX_PERIOD)) u_meter (
    .i_clk        (i_clk),
    .i_srst       (i_srst),
    .i_tone       (i_tone_in),
    .o_edge_stb   (w_edge),
    .o_period     (w_period),
    .o_silence_stb(w_silence)
  );

  assign w_note     = classify_period(w_period, PERIOD_SHIFT, TOL_SHIFT);
  assign w_cand_hit = (w_note != NOTE_REST) && (w_note == r_cand);
  assign w_live_hit = (w_note == r_live);
  assign w_time_inc = tick_inc(r_time);
  assign w_miss_inc = tick_inc(r_miss_time);
  assign w_dur_now  = r_time[PRE_W +: DUR_W];
  assign w_new_cnt  = (w_note == NOTE_REST) ? '0 : CNT_W'(1);

  always_comb begin
    w_emit      = 1'b0;
    w_emit_note = r_live;
    w_emit_dur  = r_frozen;
    case (r_state)
      TRACK: begin
        if (w_silence || (w_edge && !w_live_hit && r_miss == CNT_LAST)) w_emit = 1'b1;
      end
`ifdef REST_REPORT_EN
      SILENT: begin
        if (w_edge && r_rest_armed) begin
          w_emit      = 1'b1;
          w_emit_note = NOTE_REST;
          w_emit_dur  = w_dur_now;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_state     <= SILENT;
      r_time      <= '0;
      r_miss_time <= '0;
      r_frozen    <= '0;
      r_cand      <= NOTE_REST;
      r_live      <= NOTE_REST;
      r_cnt       <= '0;
      r_miss      <= '0;
      r_valid     <= 1'b0;
      r_note_out  <= NOTE_REST;
      r_dur_out   <= '0;
      r_overrun   <= 1'b0;
`ifdef REST_REPORT_EN
      r_rest_armed <= 1'b0;
`endif
    end else begin
      r_time      <= w_time_inc;
      r_miss_time <= w_miss_inc;
`ifdef REST_REPORT_EN
      if (w_silence) r_rest_armed <= 1'b1;
`endif
      case (r_state)
        SILENT: begin
          if (w_edge) begin
            r_state <= ACQUIRE;
            r_time  <= TIME_ONE;
            r_cand  <= NOTE_REST;
            r_cnt   <= '0;
          end
        end
        ACQUIRE: begin
          if (w_silence) begin
            r_state <= SILENT;
            r_time  <= TIME_ONE;
          end else if (w_edge) begin
            if (w_cand_hit) begin
              if (r_cnt == CNT_LAST) begin
                r_state  <= TRACK;
                r_live   <= r_cand;
                r_frozen <= w_dur_now;
                r_miss   <= '0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end else begin
              r_cand <= w_note;
              r_cnt  <= w_new_cnt;
            end
          end
        end
        TRACK: begin
          if (w_silence) begin
            r_state <= SILENT;
            r_live  <= NOTE_REST;
            r_time  <= TIME_ONE;
          end else if (w_edge) begin
            if (w_live_hit) begin
              r_frozen <= w_dur_now;
              r_miss   <= '0;
            end else if (r_miss == CNT_LAST) begin
              // The next note began at the first missed edge, timed by r_miss_time.
              r_state <= ACQUIRE;
              r_live  <= NOTE_REST;
              r_cand  <= w_note;
              r_cnt   <= w_new_cnt;
              r_time  <= (r_miss == '0) ? TIME_ONE : w_miss_inc;
            end else begin
              r_miss <= r_miss + 1'b1;
              if (r_miss == '0) r_miss_time <= TIME_ONE;
            end
          end
        end
        default: r_state <= SILENT;
      endcase

      if (w_emit) begin
        if (!r_valid || i_out_ready) begin
          r_valid    <= 1'b1;
          r_note_out <= w_emit_note;
          r_dur_out  <= w_emit_dur;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (i_out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_out_valid = r_valid;
  assign o_note_out  = r_note_out;
  assign o_dur_out   = r_dur_out;
  assign o_note_live = r_live;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_note_decoder.sv
// Directed bench for note_decoder with the note table scaled down by 2^9 to keep runs short.
module tb_note_decoder;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic          tone = 1'b0;
  logic          ready = 1'b0;
  logic          o_out_valid;
  logic [3:0]    o_note_out;
  logic [DW-1:0] o_dur_out;
  logic [3:0]    o_note_live;
  logic          o_overrun;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0]    q_note [$];
  logic [DW-1:0] q_dur  [$];

  always #5 clk = ~clk;

  note_decoder #(
    .TICK_CYCLES (500),
    .MAX_PERIOD  (500),
    .STABLE_CNT  (4),
    .TOL_SHIFT   (5),
    .DUR_W       (DW),
    .PERIOD_SHIFT(9)
  ) dut (
    .i_clk      (clk),
    .i_srst     (srst),
    .i_tone_in  (tone),
    .i_out_ready(ready),
    .o_out_valid(o_out_valid),
    .o_note_out (o_note_out),
    .o_dur_out  (o_dur_out),
    .o_note_live(o_note_live),
    .o_overrun  (o_overrun)
  );

  // Records handed over on valid && ready.
  always @(negedge clk) begin
    if (o_out_valid && ready) begin
      q_note.push_back(o_note_out);
      q_dur.push_back(o_dur_out);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic play(input int per, input int n);
    for (int i = 0; i < n; i++) begin
      tone = 1'b1;
      step(per / 2);
      tone = 1'b0;
      step(per - per / 2);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic get_rec(input string tag, input int en, input int ed);
    int         waited;
    int         n;
    logic [3:0] got_note;
    logic [DW-1:0] got_dur;
    waited = 0;
    while (q_note.size() == 0 && waited < 3000) begin
      step(1);
      waited++;
    end
    n = q_note.size();
    chk({tag, "_present"}, 32'(n != 0), 32'd1);
    if (n != 0) begin
      got_note = q_note.pop_front();
      got_dur  = q_dur.pop_front();
      chk({tag, "_note"}, 32'(got_note), 32'(en));
      chk({tag, "_dur"}, 32'(got_dur), 32'(ed));
    end
  endtask

  task automatic no_rec(input string tag, input int cycles);
    step(cycles);
    chk(tag, 32'(q_note.size()), 32'd0);
  endtask

  task automatic do_reset();
    srst  = 1'b1;
    tone  = 1'b0;
    ready = 1'b1;
    step(2);
    srst = 1'b0;
    step(1);
  endtask

  initial begin
    step(3);
    chk("rst_valid", 32'(o_out_valid), 32'd0);
    chk("rst_note", 32'(o_note_out), 32'hF);
    chk("rst_dur", 32'(o_dur_out), 32'd0);
    chk("rst_live", 32'(o_note_live), 32'hF);
    chk("rst_overrun", 32'(o_overrun), 32'd0);
    srst  = 1'b0;
    ready = 1'b1;
    step(1);

    // A4 alone, then silence.
    play(221, 6);
    chk("t1_live_acq", 32'(o_note_live), 32'd5);
    play(221, 19);
    chk("t1_live_end", 32'(o_note_live), 32'd5);
    get_rec("t1", 5, 10);
    chk("t1_live_sil", 32'(o_note_live), 32'hF);
    chk("t1_valid_drop", 32'(o_out_valid), 32'd0);

    // C4 straight into D4.
    do_reset();
    play(373, 8);
    play(332, 10);
    get_rec("t2a", 0, 5);
    get_rec("t2b", 1, 5);
    chk("t2_overrun", 32'(o_overrun), 32'd0);

    // 450 Hz accepted, 470 Hz rejected, +tolerance boundary accepted.
    do_reset();
    play(217, 10);
    get_rec("t4_450", 5, 3);
    do_reset();
    play(208, 12);
    chk("t4_470_live_mid", 32'(o_note_live), 32'hF);
    play(208, 13);
    chk("t4_470_live_end", 32'(o_note_live), 32'hF);
    no_rec("t4_470_norec", 800);
    do_reset();
    play(227, 6);
    get_rec("t4_edge", 5, 2);

    // One C4 period inside an A4 tone.
    do_reset();
    play(221, 10);
    play(373, 1);
    play(221, 12);
    get_rec("t5", 5, 10);
    no_rec("t5_single", 800);

    // Consumer stalled across three notes.
    do_reset();
    ready = 1'b0;
    play(296, 8);
    play(249, 10);
    chk("t3_hold_valid", 32'(o_out_valid), 32'd1);
    chk("t3_hold_note", 32'(o_note_out), 32'd2);
    chk("t3_hold_dur", 32'(o_dur_out), 32'd4);
    play(373, 9);
    step(600);
    chk("t3_end_valid", 32'(o_out_valid), 32'd1);
    chk("t3_end_note", 32'(o_note_out), 32'd2);
    chk("t3_end_dur", 32'(o_dur_out), 32'd4);
    chk("t3_overrun", 32'(o_overrun), 32'd1);
    chk("t3_live", 32'(o_note_live), 32'hF);
    ready = 1'b1;
    get_rec("t3", 2, 4);
    chk("t3_overrun_sticky", 32'(o_overrun), 32'd1);
    chk("t3_drained", 32'(o_out_valid), 32'd0);

    // Reset in the middle of a tracked note.
    ready = 1'b0;
    play(221, 12);
    chk("t6_overrun_pre", 32'(o_overrun), 32'd1);
    chk("t6_live_pre", 32'(o_note_live), 32'd5);
    srst = 1'b1;
    step(1);
    srst = 1'b0;
    chk("t6_valid", 32'(o_out_valid), 32'd0);
    chk("t6_live", 32'(o_note_live), 32'hF);
    chk("t6_overrun", 32'(o_overrun), 32'd0);
    chk("t6_note", 32'(o_note_out), 32'hF);
    chk("t6_dur", 32'(o_dur_out), 32'd0);
    ready = 1'b1;
    no_rec("t6_norec", 800);
    chk("t6_valid_after", 32'(o_out_valid), 32'd0);

    // Long note saturates the duration field.
    do_reset();
    play(221, 40);
    get_rec("t8_sat", 5, 15);

`ifdef REST_REPORT_EN
    // Note, rest, note.
    do_reset();
    play(221, 25);
    step(5300);
    play(221, 25);
    get_rec("t7a", 5, 10);
    get_rec("t7_rest", 15, 10);
    get_rec("t7b", 5, 10);
    no_rec("t7_tail", 800);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
